// File: rtl/i2c_gain_slave.sv
// I2C register slave exposing NUM_GAINS 8-bit gain registers at addresses 1..NUM_GAINS.
// Define I2C_GAIN_READ_EN to also serve R/W=1 (read) transfers.
module i2c_gain_slave #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h6A,
  parameter int unsigned NUM_GAINS  = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   scl,
  input  logic                   sda_in,
  output logic                   sda_oe,
  output logic [7:0]             reg_addr,
  output logic [7:0]             reg_data,
  output logic                   reg_we,
  output logic [8*NUM_GAINS-1:0] gains,
  output logic                   busy
);

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, DATA, DATA_ACK, WAIT_STOP
`ifdef I2C_GAIN_READ_EN
    , RD_DATA, RD_ACK
`endif
  } state_t;

  state_t                 r_state, w_state_nx;
  logic                   r_scl_s1, r_scl_s2, r_scl_d;
  logic                   r_sda_s1, r_sda_s2, r_sda_d;
  logic [6:0]             r_shift;
  logic [3:0]             r_bit_cnt;
  logic                   r_sda_oe;
  logic [7:0]             r_reg_addr, r_reg_data;
  logic                   r_reg_we, r_busy;
  logic [8*NUM_GAINS-1:0] r_gains;

  logic       w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0] w_rx_byte;
  logic       w_byte_done, w_addr_ok;

`ifdef I2C_GAIN_READ_EN
  logic       r_rw;
  logic [7:0] r_tx;
  logic [7:0] w_rdata;

  always_comb begin
    w_rdata = '0;
    for (int unsigned k = 1; k <= NUM_GAINS; k++)
      if (r_reg_addr == 8'(k)) w_rdata = r_gains[8*k-1 -: 8];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1; r_scl_d <= 1'b1;
      r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1; r_sda_d <= 1'b1;
    end else begin
      r_scl_s1 <= scl;    r_scl_s2 <= r_scl_s1; r_scl_d <= r_scl_s2;
      r_sda_s1 <= sda_in; r_sda_s2 <= r_sda_s1; r_sda_d <= r_sda_s2;
    end
  end

  assign w_scl_rise  = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall  = ~r_scl_s2 & r_scl_d;
  assign w_start     = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop      = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
  assign w_rx_byte   = {r_shift, r_sda_s2};
  assign w_byte_done = w_scl_rise && (r_bit_cnt == 4'd7) &&
                       (r_state == DEV_ADDR || r_state == REG_ADDR || r_state == DATA);
`ifdef I2C_GAIN_READ_EN
  assign w_addr_ok   = (w_rx_byte[7:1] == SLAVE_ADDR);
`else
  assign w_addr_ok   = (w_rx_byte[7:1] == SLAVE_ADDR) && !w_rx_byte[0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  // ACK states hold through two SCL falls: the first asserts sda_oe, the second releases it.
  always_comb begin
    w_state_nx = r_state;
    if (w_stop) w_state_nx = IDLE;
    else if (w_start) w_state_nx = DEV_ADDR;
    else begin
      case (r_state)
        DEV_ADDR: if (w_byte_done) w_state_nx = w_addr_ok ? DEV_ACK : WAIT_STOP;
        DEV_ACK:
          if (w_scl_fall && r_sda_oe) begin
`ifdef I2C_GAIN_READ_EN
            w_state_nx = r_rw ? RD_DATA : REG_ADDR;
`else
            w_state_nx = REG_ADDR;
`endif
          end
        REG_ADDR: if (w_byte_done) w_state_nx = REG_ACK;
        REG_ACK:  if (w_scl_fall && r_sda_oe) w_state_nx = DATA;
        DATA:     if (w_byte_done) w_state_nx = DATA_ACK;
        DATA_ACK: if (w_scl_fall && r_sda_oe) w_state_nx = DATA;
`ifdef I2C_GAIN_READ_EN
        RD_DATA:  if (w_scl_fall && r_bit_cnt == 4'd8) w_state_nx = RD_ACK;
        RD_ACK:
          if (w_scl_rise && r_sda_s2) w_state_nx = WAIT_STOP;
          else if (w_scl_fall && r_bit_cnt != '0) w_state_nx = RD_DATA;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_sda_oe   <= 1'b0;
      r_reg_addr <= '0;
      r_reg_data <= '0;
      r_reg_we   <= 1'b0;
      r_busy     <= 1'b0;
      r_gains    <= '0;
`ifdef I2C_GAIN_READ_EN
      r_rw       <= 1'b0;
      r_tx       <= '0;
`endif
    end else begin
      r_reg_we <= 1'b0;
      if (w_stop) begin
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b0;
        r_bit_cnt <= '0;
      end else if (w_start) begin
        r_sda_oe  <= 1'b0;
        r_bit_cnt <= '0;
      end else begin
        case (r_state)
          DEV_ADDR, REG_ADDR, DATA:
            if (w_scl_rise) begin
              r_shift   <= w_rx_byte[6:0];
              r_bit_cnt <= w_byte_done ? 4'd0 : r_bit_cnt + 4'd1;
              if (w_byte_done) begin
                if (r_state == DEV_ADDR) begin
                  r_busy <= w_addr_ok;
`ifdef I2C_GAIN_READ_EN
                  r_rw   <= w_rx_byte[0];
`endif
                end else if (r_state == REG_ADDR) begin
                  r_reg_addr <= w_rx_byte;
                end else begin
                  r_reg_data <= w_rx_byte;
                  r_reg_we   <= 1'b1;
                  for (int unsigned k = 1; k <= NUM_GAINS; k++)
                    if (r_reg_addr == 8'(k)) r_gains[8*k-1 -: 8] <= w_rx_byte;
                end
              end
            end
          DEV_ACK, REG_ACK, DATA_ACK:
            if (w_scl_fall) begin
              r_sda_oe <= ~r_sda_oe;
              if (r_sda_oe && r_state == DATA_ACK) r_reg_addr <= r_reg_addr + 8'd1;
`ifdef I2C_GAIN_READ_EN
              // Read transfer: first data bit goes out on the same fall that ends the ACK.
              if (r_sda_oe && r_state == DEV_ACK && r_rw) begin
                r_sda_oe <= ~w_rdata[7];
                r_tx     <= {w_rdata[6:0], 1'b0};
              end
`endif
            end
`ifdef I2C_GAIN_READ_EN
          RD_DATA:
            if (w_scl_rise) r_bit_cnt <= r_bit_cnt + 4'd1;
            else if (w_scl_fall) begin
              if (r_bit_cnt == 4'd8) begin
                r_sda_oe   <= 1'b0;
                r_bit_cnt  <= '0;
                r_reg_addr <= r_reg_addr + 8'd1;
              end else if (r_bit_cnt != '0) begin
                r_sda_oe <= ~r_tx[7];
                r_tx     <= {r_tx[6:0], 1'b0};
              end
            end
          RD_ACK:
            if (w_scl_rise) r_bit_cnt <= 4'd1;
            else if (w_scl_fall && r_bit_cnt != '0) begin
              r_bit_cnt <= '0;
              r_sda_oe  <= ~w_rdata[7];
              r_tx      <= {w_rdata[6:0], 1'b0};
            end
`endif
          default: ;
        endcase
      end
    end
  end

  assign sda_oe   = r_sda_oe;
  assign reg_addr = r_reg_addr;
  assign reg_data = r_reg_data;
  assign reg_we   = r_reg_we;
  assign gains    = r_gains;
  assign busy     = r_busy;

endmodule
